// File: rtl/cnn_pkg.sv
// Shared types and default sizing for the ReLU stream stage.
package cnn_pkg;

  localparam int N_DEF         = 14;
  localparam int FRAME_LEN_DEF = 676;
  localparam int CNT_W_DEF     = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/relu_stream_ctrl_if.sv
// Control and valid/ready stream signals between conv engine, ReLU stage and pooling.
interface relu_stream_ctrl_if
  import cnn_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();

  logic                start;
  logic                in_valid;
  logic signed [N-1:0] in_data;
  logic                in_ready;
  logic                out_valid;
  logic signed [N-1:0] out_data;
  logic                out_ready;
  logic                busy;
  logic                done;
  logic [CNT_W-1:0]    zero_cnt;

  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, done, zero_cnt
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, done, zero_cnt
  );

endinterface

// File: rtl/relu.sv
// Combinational ReLU clamp: negative two's-complement inputs become zero.
module relu #(
  parameter int N = 14
) (
  input  logic signed [N-1:0] din,
  output logic signed [N-1:0] dout
);

  function automatic logic signed [N-1:0] clamp_neg(input logic signed [N-1:0] x);
    return x[N-1] ? '0 : x;
  endfunction

  always_comb begin
    dout = clamp_neg(din);
  end

endmodule

// File: rtl/relu_stream_ctrl.sv
// Frame sequencer for the ReLU stream stage: one registered output slot,
// element counting, clamp statistics and a done pulse after the last word leaves.
module relu_stream_ctrl
  import cnn_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  relu_stream_ctrl_if.slave  s
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]    zero_cnt_q, zero_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic signed [N-1:0] out_data_q, out_data_d;
  logic signed [N-1:0] relu_y;
  logic                in_ready;
  logic                accept;
  logic                emit;

  relu #(.N(N)) u_relu (
    .din  (s.in_data),
    .dout (relu_y)
  );

  always_comb begin
    in_ready = (state_q == RUN) && (!out_valid_q || s.out_ready);
    accept   = s.in_valid && in_ready;
    emit     = out_valid_q && s.out_ready;
  end

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    zero_cnt_d  = zero_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    // A simultaneous accept and emit reloads the slot, keeping 1 word/cycle.
    if (accept) begin
      out_data_d  = relu_y;
      out_valid_d = 1'b1;
      in_cnt_d    = in_cnt_q + CNT_W'(1);
      if (s.in_data[N-1]) begin
        zero_cnt_d = zero_cnt_q + CNT_W'(1);
      end
    end else if (emit) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (s.start) begin
          state_d    = RUN;
          in_cnt_d   = '0;
          zero_cnt_d = '0;
        end
      end
      RUN: begin
        if (accept && (in_cnt_q == LAST)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!out_valid_q || s.out_ready) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_cnt_q    <= '0;
      zero_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      zero_cnt_q  <= zero_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign s.in_ready  = in_ready;
  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;
  assign s.busy      = (state_q != IDLE);
  assign s.done      = (state_q == DONE);
  assign s.zero_cnt  = zero_cnt_q;

endmodule

// File: tb/tb_relu_stream_ctrl.sv
// Directed bench: a 4-word-frame instance for short sequences and a 676-word instance
// for abort, back-pressure and full-throughput frames.
module tb_relu_stream_ctrl;

  localparam int N     = 14;
  localparam int CNT_W = 10;
  localparam int FL    = 676;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  relu_stream_ctrl_if #(.N(N), .CNT_W(CNT_W)) if4 ();
  relu_stream_ctrl_if #(.N(N), .CNT_W(CNT_W)) ifb ();

  relu_stream_ctrl #(.N(N), .FRAME_LEN(4), .CNT_W(CNT_W)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .s   (if4)
  );

  relu_stream_ctrl #(.N(N), .FRAME_LEN(FL), .CNT_W(CNT_W)) u_dutb (
    .clk (clk),
    .rst (rst),
    .s   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus word k: mixes positives, negatives and the most-negative code.
  function automatic int f(input int k);
    if (k == 2) return -8192;
    if (k % 3 == 1) return -(k * 7);
    return k * 5;
  endfunction

  function automatic int relu_ref(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  function automatic int negs(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) if (f(k) < 0) c++;
    return c;
  endfunction

  int v4[4] = '{5, -3, 0, -8192};
  int e4[4] = '{5, 0, 0, 0};

  initial begin
    int sent, recv, stall, ndone, nout, first_ov, last_ov, done_e;
    logic first, held, acc, emt, fin;
    logic signed [N-1:0] held_d;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    if4.start = 1'b0; if4.in_valid = 1'b0; if4.in_data = '0; if4.out_ready = 1'b1;
    ifb.start = 1'b0; ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b1;

    // Reset state
    tick();
    rst = 1'b0;
    chk("rst_busy", ifb.busy, 0);
    chk("rst_done", ifb.done, 0);
    chk("rst_in_ready", ifb.in_ready, 0);
    chk("rst_out_valid", ifb.out_valid, 0);
    chk("rst_out_data", ifb.out_data, 0);
    chk("rst_zero_cnt", ifb.zero_cnt, 0);
    chk("rst4_busy", if4.busy, 0);
    chk("rst4_out_valid", if4.out_valid, 0);

    // Abort mid-frame after 300 words
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    chk("abort_busy_run", ifb.busy, 1);
    ifb.in_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      ifb.in_data = N'(f(k));
      tick();
    end
    chk("abort_zero_pre", ifb.zero_cnt, negs(300));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("abort_busy", ifb.busy, 0);
    chk("abort_out_valid", ifb.out_valid, 0);
    chk("abort_out_data", ifb.out_data, 0);
    chk("abort_zero_cnt", ifb.zero_cnt, 0);
    chk("abort_in_ready", ifb.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", ifb.done, 0);
    end
    ifb.in_valid = 1'b0;

    // rst and start together
    rst = 1'b1;
    ifb.start = 1'b1;
    tick();
    rst = 1'b0;
    ifb.start = 1'b0;
    chk("rst_start_busy", ifb.busy, 0);

    // Short frame, 4 words
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    chk("f4_busy", if4.busy, 1);
    chk("f4_in_ready", if4.in_ready, 1);
    if4.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if4.in_data = N'(v4[i]);
      tick();
      chk("f4_out_valid", if4.out_valid, 1);
      chk("f4_out_data", if4.out_data, e4[i]);
    end
    if4.in_valid = 1'b0;
    #1;
    chk("f4_drain_in_ready", if4.in_ready, 0);
    chk("f4_drain_done", if4.done, 0);
    tick();
    chk("f4_done", if4.done, 1);
    chk("f4_done_out_valid", if4.out_valid, 0);
    chk("f4_zero_cnt", if4.zero_cnt, 2);
    tick();
    chk("f4_done_pulse", if4.done, 0);
    chk("f4_idle_busy", if4.busy, 0);
    chk("f4_zero_hold", if4.zero_cnt, 2);

    // in_valid while idle
    if4.in_valid = 1'b1;
    if4.in_data = N'(-5);
    #1;
    chk("idle_in_ready", if4.in_ready, 0);
    tick();
    chk("idle_out_valid", if4.out_valid, 0);
    chk("idle_zero_cnt", if4.zero_cnt, 2);
    chk("idle_busy", if4.busy, 0);
    if4.in_valid = 1'b0;

    // start during RUN and DONE is ignored
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    chk("s5_zero_clear", if4.zero_cnt, 0);
    if4.in_valid = 1'b1;
    if4.in_data = N'(-1);
    tick();
    if4.in_data = N'(-2);
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    chk("s5_run_zero", if4.zero_cnt, 2);
    chk("s5_run_busy", if4.busy, 1);
    if4.in_data = N'(-3);
    tick();
    if4.in_data = N'(-4);
    tick();
    if4.in_valid = 1'b0;
    chk("s5_zero4", if4.zero_cnt, 4);
    tick();
    chk("s5_done", if4.done, 1);
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    chk("s5_done_start_busy", if4.busy, 0);
    chk("s5_zero_hold", if4.zero_cnt, 4);
    tick();
    chk("s5_still_idle", if4.busy, 0);
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    chk("s5_restart_busy", if4.busy, 1);
    chk("s5_restart_zero", if4.zero_cnt, 0);
    if4.in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      if4.in_data = N'(i);
      tick();
    end
    if4.in_valid = 1'b0;
    tick();
    chk("s5_done2", if4.done, 1);
    tick();
    chk("s5_idle2", if4.busy, 0);

    // Back-pressure: 3 stalled cycles after the first output
    sent = 0; recv = 0; stall = 0; ndone = 0;
    first = 1'b0; held = 1'b0; fin = 1'b0; held_d = '0;
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    for (int c = 0; c < 2000 && !fin; c++) begin
      ifb.in_valid  = (sent < FL);
      ifb.in_data   = N'(f(sent));
      ifb.out_ready = (stall == 0);
      #1;
      if (ifb.out_valid && !ifb.out_ready) chk("bp_in_ready", ifb.in_ready, 0);
      if (held) begin
        chk("bp_hold_valid", ifb.out_valid, 1);
        chk("bp_hold_data", ifb.out_data, held_d);
      end
      held   = ifb.out_valid && !ifb.out_ready;
      held_d = ifb.out_data;
      acc    = ifb.in_valid && ifb.in_ready;
      emt    = ifb.out_valid && ifb.out_ready;
      if (emt) begin
        chk("bp_data", ifb.out_data, relu_ref(f(recv)));
        recv++;
      end
      if (acc) sent++;
      if (stall > 0) stall--;
      if (!first && ifb.out_valid) begin
        first = 1'b1;
        stall = 3;
      end
      tick();
      if (ifb.done) ndone++;
      if (ndone > 0 && !ifb.busy) fin = 1'b1;
    end
    chk("bp_finished", fin, 1);
    chk("bp_sent", sent, FL);
    chk("bp_recv", recv, FL);
    chk("bp_done_pulses", ndone, 1);
    chk("bp_zero_cnt", ifb.zero_cnt, negs(FL));

    // Full throughput: edge 0 samples start
    ifb.in_valid  = 1'b1;
    ifb.out_ready = 1'b1;
    ifb.in_data   = N'(f(0));
    ifb.start     = 1'b1;
    tick();
    ifb.start = 1'b0;
    nout = 0; first_ov = 0; last_ov = 0; done_e = 0;
    for (int e = 1; e <= 720 && done_e == 0; e++) begin
      tick();
      ifb.in_data = N'(f(e));
      if (ifb.out_valid) begin
        chk("ft_data", ifb.out_data, relu_ref(f(nout)));
        nout++;
        if (first_ov == 0) first_ov = e;
        last_ov = e;
      end
      if (ifb.done) done_e = e;
    end
    ifb.in_valid = 1'b0;
    chk("ft_count", nout, FL);
    chk("ft_first_out", first_ov, 1);
    chk("ft_last_out", last_ov, FL);
    chk("ft_done_edge", done_e, FL + 1);
    chk("ft_zero_cnt", ifb.zero_cnt, negs(FL));
    tick();
    chk("ft_idle", ifb.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
